alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised, handshaked successor to the single-cycle datapath ALU. It adds iterative signed/unsigned multiply and divide with a HI/LO result pair, an unsigned compare, and an overflow-correct signed compare. It sits in the execute stage of the multi-cycle and pipelined cores, and stalls the stage through a valid/ready handshake while an iterative operation is running.

## Interface
- `WIDTH`, 32: operand and result width; must be even and ≥ 8.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `in_valid` in, 1: operands and op are valid this cycle.
- `in_ready` out, 1: unit can accept; high only in IDLE.
- `a` in, WIDTH: first operand (rs).
- `b` in, WIDTH: second operand (rt or immediate).
- `alu_control` in, 4: operation select.
- `out_valid` out, 1: result registers are valid; held until accepted.
- `out_ready` in, 1: consumer accepts the result.
- `result` out, WIDTH: primary result (LO for mul/div).
- `result_hi` out, WIDTH: HI (mul upper half / div remainder), 0 otherwise.
- `zero` out, 1: `result == 0`, registered with `result`.
- `err` out, 1: divide-by-zero or unsupported op.

## Operation
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR.
  - 0110 SUB; 0111 SLT (signed); 0100 SLTU.
  - 1000 MULTU; 1001 MULT; 1010 DIVU; 1011 DIV.
  - All other codes: result 0, result_hi 0, err 1.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT uses a true signed compare, including the case where `a−b` overflows. SLT and SLTU return 0 or 1 zero-extended.
- States:
  - IDLE: `in_ready=1`. On `in_valid`, latch the op. Single-cycle ops and divide-by-zero go to DONE. Multiply goes to MUL; divide goes to DIV.
  - MUL / DIV: one shift-add or restoring-subtract step per cycle for exactly WIDTH cycles, then DONE.
  - DONE: `out_valid=1`. On `out_ready`, go to IDLE.
- Signed mul/div: operate on magnitudes, apply the signs when loading DONE.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV/DIVU, `b=0`): result all-ones, result_hi = `a`, err 1, no iteration.
- DIV of MIN/−1: result MIN, result_hi 0, err 0.
- `result`, `result_hi`, `zero` and `err` change only on entry to DONE and stay stable while `out_valid` is high.

## Timing
- Reset values:
  - state IDLE, `in_ready` 1, `out_valid` 0.
  - `result` 0, `result_hi` 0, `zero` 0, `err` 0.
- Accept in cycle N:
  - Single-cycle ops, unsupported ops and divide-by-zero: `out_valid` high in N+1.
  - MUL and DIV: `out_valid` high in N+1+WIDTH.
- `in_ready` is a decode of state only; there is no combinational path from `out_ready` to `in_ready`.
- Maximum throughput is one operation every 2 cycles.
- If `out_ready` is already high when `out_valid` rises, the result is consumed that cycle and `in_ready` is high in the following cycle.
- `rst` in any state aborts the operation: no `out_valid` for it, and IDLE with reset values in the next cycle.
- Operand changes after acceptance have no effect.

## Configuration
- Macro `ALU_MULDIV_DIV_EN`.
- Defined: DIV/DIVU behave as specified above.
- Undefined:
  - Divider logic is omitted and the DIV state does not exist.
  - Codes 1010/1011 are treated as unsupported: result 0, result_hi 0, err 1, `out_valid` in N+1.
  - MUL is unaffected.

## Structure
- Shared package `alu_pkg` holds:
  - 4-bit op-code localparams.
  - The state enum (IDLE, MUL, DIV, DONE).
  - Reset constants.
- One sub-module, `muldiv_iter`: the WIDTH-step iterative datapath.
  - Holds the accumulator/remainder, multiplier/quotient shift register and step counter.
  - Exposes `start`, `is_div` and `step_done`.
  - The top holds the FSM, the single-cycle ops, sign handling and output registers.

## Test plan
- ADD, `a=0x7FFFFFFF`, `b=1`, `out_ready=1` → `out_valid` at N+1; result `0x80000000`, zero 0, err 0. SUB with `a=b=5` → result 0, zero 1.
- SLT with `a=0x7FFFFFFF`, `b=0x80000000` → 0. SLTU with the same operands → 1. SLT with `a=0x80000000`, `b=1` → 1.
- MULT, `a=0xFFFFFFFD` (−3), `b=7` → `out_valid` at N+33; result `0xFFFFFFEB`, result_hi `0xFFFFFFFF`. MULTU with `a=b=0xFFFFFFFF` → result 1, result_hi `0xFFFFFFFE`.
- DIV, `a=0xFFFFFFF9` (−7), `b=2` → result `0xFFFFFFFD`, result_hi `0xFFFFFFFF` at N+33. DIVU with `a=9`, `b=0` → result `0xFFFFFFFF`, result_hi 9, err 1 at N+1.
- Hold `out_ready` low for 5 cycles after `out_valid` → outputs stable and `in_ready` 0 throughout. An `in_valid` presented during that window is not accepted.
- Assert `rst` in the 10th MULT iteration cycle → `out_valid` never rises for that op. In the next cycle `in_ready` is 1 and all outputs hold reset values. Repeat with `ALU_MULDIV_DIV_EN` undefined: DIV → err 1 at N+1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_muldiv execute-stage unit.
//   - 4-bit operation codes driven on alu_control
//   - FSM state encoding (IDLE, MUL, DIV, DONE)
//   - reset constants for the control state and the status flags
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_ZERO  = 1'b0;
  localparam logic   RST_ERR   = 1'b0;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: WIDTH-step iterative unsigned multiply / restoring divide.
// Operands are unsigned magnitudes; sign handling lives in the caller.
// Build option: ALU_MULDIV_DIV_EN includes the restoring divider; without it
// a start with is_div set is ignored.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load op_a/op_b and begin WIDTH steps
//   is_div        1 = divide, 0 = multiply (sampled with start)
//   op_a, op_b    multiplicand/multiplier or dividend/divisor magnitudes
//   step_done     high during the last (WIDTH-th) step cycle
//   hi_next       accumulator after this cycle's step (product high / remainder)
//   lo_next       shift register after this cycle's step (product low / quotient)
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             step_done,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   sum;
`ifdef ALU_MULDIV_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   rem_shift;
`endif

  always_comb begin
    // Shift-add: add the multiplicand when the current multiplier LSB is set,
    // then shift {carry, acc, mq} right by one.
    sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    acc_d = sum[WIDTH:1];
    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits; the quotient bit shifts into mq.
    rem_shift = {acc_q, mq_q[WIDTH-1]};
    if (div_q) begin
      if (rem_shift >= {1'b0, b_q}) begin
        acc_d = rem_shift[WIDTH-1:0] - b_q;
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_shift[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  assign step_done = busy_q && (cnt_q == CW'(WIDTH - 1));
  // Post-step values let the caller capture the final result on the same
  // edge as the last step, with no extra drain cycle.
  assign hi_next   = acc_d;
  assign lo_next   = mq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (start) begin
      acc_q  <= '0;
      mq_q   <= op_a;
      b_q    <= op_b;
      cnt_q  <= '0;
`ifdef ALU_MULDIV_DIV_EN
      busy_q <= 1'b1;
      div_q  <= is_div;
`else
      busy_q <= !is_div;
`endif
    end else if (busy_q) begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      cnt_q <= cnt_q + CW'(1);
      if (step_done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: handshaked execute-stage ALU with iterative mul/div.
// Single-cycle ops complete in one cycle; MULT/MULTU (and DIV/DIVU when
// ALU_MULDIV_DIV_EN is defined) take WIDTH iteration cycles in muldiv_iter.
// Without ALU_MULDIV_DIV_EN the divide codes are reported as unsupported.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready only in IDLE)
//   a, b, alu_control    operands and op code
//   out_valid/out_ready  result handshake (held until accepted)
//   result, result_hi    LO / HI result registers
//   zero, err            result==0, divide-by-zero or unsupported op
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             err
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, err_q, err_d;
  logic               load;
  logic               neg_lo_q, neg_lo_d;
`ifdef ALU_MULDIV_DIV_EN
  logic               neg_hi_q, neg_hi_d;
`endif
  logic               start, is_div, step_done;
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b, iter_hi, iter_lo;
  logic [2*WIDTH-1:0] prod;

  assign signed_op = (alu_control == OP_MULT) || (alu_control == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  // MIN negates to itself, which is its correct unsigned magnitude.
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_div    (is_div),
    .op_a      (mag_a),
    .op_b      (mag_b),
    .step_done (step_done),
    .hi_next   (iter_hi),
    .lo_next   (iter_lo)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    result_d = '0;
    hi_d     = '0;
    err_d    = 1'b0;
    neg_lo_d = neg_lo_q;
`ifdef ALU_MULDIV_DIV_EN
    neg_hi_d = neg_hi_q;
`endif
    start    = 1'b0;
    is_div   = 1'b0;
    prod     = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          load    = 1'b1;
          case (alu_control)
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_ADD:  result_d = a + b;
            OP_XOR:  result_d = a ^ b;
            OP_SUB:  result_d = a - b;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MULTU, OP_MULT: begin
              load     = 1'b0;
              start    = 1'b1;
              state_d  = ST_MUL;
              neg_lo_d = a_neg ^ b_neg;
            end
`ifdef ALU_MULDIV_DIV_EN
            OP_DIVU, OP_DIV: begin
              if (b == '0) begin
                result_d = '1;
                hi_d     = a;
                err_d    = 1'b1;
              end else begin
                load     = 1'b0;
                start    = 1'b1;
                is_div   = 1'b1;
                state_d  = ST_DIV;
                neg_lo_d = a_neg ^ b_neg;  // quotient sign
                neg_hi_d = a_neg;          // remainder follows the dividend
              end
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_MUL: begin
        if (step_done) begin
          // Negate the full double-width product so HI sees the borrow.
          prod = {iter_hi, iter_lo};
          if (neg_lo_q) prod = -prod;
          result_d = prod[WIDTH-1:0];
          hi_d     = prod[2*WIDTH-1:WIDTH];
          load     = 1'b1;
          state_d  = ST_DONE;
        end
      end
`ifdef ALU_MULDIV_DIV_EN
      ST_DIV: begin
        if (step_done) begin
          result_d = neg_lo_q ? -iter_lo : iter_lo;
          hi_d     = neg_hi_q ? -iter_hi : iter_hi;
          load     = 1'b1;
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RST_STATE;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= RST_ZERO;
      err_q    <= RST_ERR;
      neg_lo_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      neg_lo_q <= neg_lo_d;
`ifdef ALU_MULDIV_DIV_EN
      neg_hi_q <= neg_hi_d;
`endif
      // Output registers only move on entry to DONE.
      if (load) begin
        result_q <= result_d;
        hi_q     <= hi_d;
        zero_q   <= (result_d == '0);
        err_q    <= err_d;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: table-driven directed test of alu_muldiv (WIDTH=32) plus
// hand-written sequences for back-pressure and reset during an iteration.
// Honours ALU_MULDIV_DIV_EN to select divide expectations.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         zero, err;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .err         (err)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         e;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void addv(input string nm, input logic [3:0] op,
                               input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic [W-1:0] r, input logic [W-1:0] h,
                               input logic z, input logic e, input int lat);
    vec_t v;
    v.name = nm; v.op = op; v.a = va; v.b = vb;
    v.res = r; v.hi = h; v.z = z; v.e = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Apply one vector with out_ready held high; check latency, outputs and
  // that in_ready returns the cycle after the result is consumed.
  task automatic apply(input vec_t v);
    int g;
    int lat;
    g = 0;
    while (!in_ready && g < 100) begin tick(); g++; end
    chk({v.name, " in_ready before issue"}, in_ready, 1);
    alu_control = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Operand changes after acceptance must not affect the result.
    a = ~v.a; b = v.b ^ 32'h5A5A_A5A5; alu_control = OP_AND;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    $display("%-10s a=%08h b=%08h -> res=%08h hi=%08h z=%0d e=%0d lat=%0d",
             v.name, v.a, v.b, result, result_hi, zero, err, lat);
    chk({v.name, " latency"}, lat, v.lat);
    chk({v.name, " result"}, result, v.res);
    chk({v.name, " result_hi"}, result_hi, v.hi);
    chk({v.name, " zero"}, zero, v.z);
    chk({v.name, " err"}, err, v.e);
    tick();
    chk({v.name, " in_ready after consume"}, in_ready, 1);
    chk({v.name, " out_valid after consume"}, out_valid, 0);
  endtask

  initial begin
    int  g;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset result_hi", result_hi, 0);
    chk("reset zero", zero, 0);
    chk("reset err", err, 0);

    addv("ADD",    OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 1'b0, 1'b0, 1);
    addv("SUB0",   OP_SUB,   32'd5,        32'd5,        32'h0,        32'h0, 1'b1, 1'b0, 1);
    addv("SUBNEG", OP_SUB,   32'd3,        32'd5,        32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1);
    addv("SLT1",   OP_SLT,   32'h7FFFFFFF, 32'h80000000, 32'h0,        32'h0, 1'b1, 1'b0, 1);
    addv("SLTU",   OP_SLTU,  32'h7FFFFFFF, 32'h80000000, 32'h1,        32'h0, 1'b0, 1'b0, 1);
    addv("SLT2",   OP_SLT,   32'h80000000, 32'h1,        32'h1,        32'h0, 1'b0, 1'b0, 1);
    addv("AND",    OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1);
    addv("OR",     OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 32'h0, 1'b0, 1'b0, 1);
    addv("XOR",    OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1'b0, 1'b0, 1);
    addv("UNSUP5", 4'b0101,  32'h12345678, 32'h9,        32'h0,        32'h0, 1'b1, 1'b1, 1);
    addv("UNSUPF", 4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0, 1'b1, 1'b1, 1);
    addv("MULT1",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
    addv("MULTU1", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFE, 1'b0, 1'b0, 33);
    addv("MULTU2", OP_MULTU, 32'h00010000, 32'h00010000, 32'h0,        32'h1,        1'b1, 1'b0, 33);
    addv("MULTMIN",OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 1'b1, 1'b0, 33);
    addv("MULTNN", OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 33);
    addv("MULTPN", OP_MULT,  32'd5,        32'hFFFFFFFC, 32'hFFFFFFEC, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
`ifdef ALU_MULDIV_DIV_EN
    addv("DIV1",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
    addv("DIVU0",  OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b1, 1);
    addv("DIVMIN", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0, 33);
    addv("DIVU1",  OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33);
    addv("DIV2",   OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 33);
    addv("DIVU2",  OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 33);
    addv("DIV00",  OP_DIV,   32'd0,        32'd0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1);
`else
    addv("DIVOFF", OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        1'b1, 1'b1, 1);
    addv("DIVUOFF",OP_DIVU,  32'd9,        32'd0,        32'h0,        32'h0,        1'b1, 1'b1, 1);
`endif

    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Back-pressure: result held with out_ready low; new in_valid ignored.
    out_ready = 1'b0;
    alu_control = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall out_valid rises", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      if (k >= 1) begin
        alu_control = OP_ADD; a = 32'd100; b = 32'd100; in_valid = 1'b1;
      end
      chk("stall result", result, 32'd3);
      chk("stall zero", zero, 0);
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
      tick();
    end
    $display("STALL      result held at %08h for 5 cycles", result);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall consumed out_valid", out_valid, 0);
    chk("stall consumed in_ready", in_ready, 1);
    tick();
    chk("stall no accept out_valid", out_valid, 0);
    chk("stall no accept result", result, 32'd3);

    // Reset in the 10th MULT iteration cycle aborts the operation.
    out_ready = 1'b1;
    alu_control = OP_MULT; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul busy in_ready", in_ready, 0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort result", result, 0);
    chk("abort result_hi", result_hi, 0);
    chk("abort zero", zero, 0);
    chk("abort err", err, 0);
    seen = 1'b0;
    g = 0;
    while (g < 60) begin
      if (out_valid) seen = 1'b1;
      tick();
      g++;
    end
    chk("abort no out_valid", seen, 0);
    $display("ABORT      MULT reset at iteration 10, out_valid seen=%0d", seen);

    // Unit still works after the abort.
    begin
      vec_t v;
      v.name = "POSTRST"; v.op = OP_MULTU; v.a = 32'd6; v.b = 32'd7;
      v.res = 32'd42; v.hi = 32'h0; v.z = 1'b0; v.e = 1'b0; v.lat = 33;
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
